// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and monitor state encoding
//
// Contents:
//   state_t  : monitor FSM states ST_FILL, ST_ACQUIRE, ST_LOCKED (2-bit)
//   gray2bin : Gray to binary decode, 32-bit container, zero-extend narrower words
//   bin2gray : binary to Gray encode, 32-bit container
package gray_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Upper bits of a zero-extended word stay zero through the prefix XOR,
    // so narrower counts decode correctly in the low bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational N-bit Gray to binary XOR-prefix decoder
//
// Ports:
//   gray : N-bit Gray-coded input
//   bin  : N-bit binary result, bin[N-1]=gray[N-1], bin[i]=bin[i+1]^gray[i]
module gray_to_bin #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // Built in a local variable so the bit-to-bit chain is a single
    // procedural evaluation rather than a self-referencing vector net.
    always_comb begin
        logic [N-1:0] b;
        b = gray;
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gray[i];
        end
        bin = b;
    end

endmodule

// File: rtl/gray_count_monitor.sv
// rtl/gray_count_monitor.sv - checks an N-bit Gray count for +1 mod 2^N steps
//
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-high reset
//   gray_in : Gray-coded count under observation
//   clear   : synchronous re-acquire, returns to FILL and zeroes err_cnt
//   bin_out : binary value of the last accepted or resynced Gray word
//   step    : one-cycle pulse per legal +1 transition
//   err     : one-cycle pulse per illegal transition
//   err_cnt : illegal transition count, saturating at 2^E-1
//   locked  : high once a reference value has been acquired
module gray_count_monitor
    import gray_pkg::*;
#(
    parameter int N = 8,
    parameter int E = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] gray_in,
    input  logic         clear,
    output logic [N-1:0] bin_out,
    output logic         step,
    output logic         err,
    output logic [E-1:0] err_cnt,
    output logic         locked
);

    localparam logic [E-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};

    state_t         state;
    state_t         state_n;
    logic [N-1:0]   g_s1;
    logic [N-1:0]   b_s1;
    logic [N-1:0]   bin_inc;
    logic [N-1:0]   bin_n;
    logic           step_n;
    logic           err_n;
    logic [E-1:0]   cnt_n;
    logic           locked_n;

    gray_to_bin #(.N(N)) u_dec (
        .gray (g_s1),
        .bin  (b_s1)
    );

    // N-bit add, so the all-ones value wraps to zero and counts as legal.
    assign bin_inc = bin_out + ONE_N;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_s1    <= '0;
            state   <= ST_FILL;
            bin_out <= '0;
            step    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            g_s1    <= gray_in;
            state   <= state_n;
            bin_out <= bin_n;
            step    <= step_n;
            err     <= err_n;
            err_cnt <= cnt_n;
            locked  <= locked_n;
        end
    end

    always_comb begin
        state_n  = state;
        bin_n    = bin_out;
        step_n   = 1'b0;
        err_n    = 1'b0;
        cnt_n    = err_cnt;
        locked_n = locked;

        if (clear) begin
            // bin_out deliberately holds so the last known value stays visible.
            state_n  = ST_FILL;
            locked_n = 1'b0;
            cnt_n    = '0;
        end else begin
            case (state)
                ST_FILL: begin
                    // g_s1 needs one edge to hold a genuine sample.
                    state_n = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    bin_n    = b_s1;
                    locked_n = 1'b1;
                    state_n  = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (b_s1 == bin_out) begin
                        bin_n = bin_out;
                    end else if (b_s1 == bin_inc) begin
                        step_n = 1'b1;
                        bin_n  = b_s1;
                    end else begin
                        // Resync to the observed value so one glitch is one error.
                        err_n = 1'b1;
                        bin_n = b_s1;
                        if (err_cnt != CNT_MAX) begin
                            cnt_n = err_cnt + {{(E-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_n = ST_FILL;
                end
            endcase
        end
    end

endmodule
